// File: rtl/wb_trace_buffer.sv
// Circular trace of architectural register writes leaving WB, with a
// step-through view for the display. Purely observational; never stalls.
module wb_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RegWrite_In,
  input  logic [4:0]        RegDest_In,
  input  logic [31:0]       WriteData_In,
  input  logic [31:0]       PC_In,
  input  logic              Freeze,
  input  logic              Step,
  input  logic              Clear,
  output logic [4:0]        Trace_RegDest,
  output logic [31:0]       Trace_Data,
  output logic [31:0]       Trace_PC,
  output logic [ADDR_W-1:0] Trace_Index,
  output logic [ADDR_W:0]   Count,
  output logic              Valid,
  output logic              Overflow
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PONE_C  = ADDR_W'(1);

  logic [68:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] wrPtr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W-1:0] view_r;
  logic              overflow_r;
  logic              valid_r;
  logic              stepQ_r;
  logic [4:0]        traceDest_r;
  logic [31:0]       traceData_r;
  logic [31:0]       tracePc_r;

  logic              capture_s;
  logic              stepRise_s;
  logic [ADDR_W-1:0] oldest_s;
  logic [ADDR_W-1:0] viewAddr_s;
  logic [ADDR_W-1:0] wrPtrNext_s;
  logic [ADDR_W:0]   countNext_s;
  logic [ADDR_W-1:0] viewNext_s;
  logic              overflowNext_s;

  // Next-state logic for pointers, count, view offset and overflow.
  always_comb begin
    capture_s      = RegWrite_In & (RegDest_In != 5'd0) & ~Freeze & ~Clear;
    stepRise_s     = Step & ~stepQ_r;
    // When full the low bits of count are zero, so oldest == wrPtr.
    oldest_s       = wrPtr_r - count_r[ADDR_W-1:0];
    viewAddr_s     = oldest_s + view_r;
    wrPtrNext_s    = wrPtr_r;
    countNext_s    = count_r;
    viewNext_s     = view_r;
    overflowNext_s = overflow_r;
    if (Clear) begin
      wrPtrNext_s    = {ADDR_W{1'b0}};
      countNext_s    = {(ADDR_W+1){1'b0}};
      viewNext_s     = {ADDR_W{1'b0}};
      overflowNext_s = 1'b0;
    end else begin
      if (capture_s) begin
        wrPtrNext_s = wrPtr_r + PONE_C;
        if (count_r == DEPTH_C) begin
          overflowNext_s = 1'b1;
        end else begin
          countNext_s = count_r + ONE_C;
        end
      end else begin
        wrPtrNext_s = wrPtr_r;
      end
      // View offset is relative to the oldest entry and wraps at Count.
      if (stepRise_s) begin
        if (count_r == {(ADDR_W+1){1'b0}}) begin
          viewNext_s = {ADDR_W{1'b0}};
        end else if ({1'b0, view_r} == count_r - ONE_C) begin
          viewNext_s = {ADDR_W{1'b0}};
        end else begin
          viewNext_s = view_r + PONE_C;
        end
      end else begin
        viewNext_s = view_r;
      end
    end
  end

  // Pointer, count, view and status registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr_r    <= {ADDR_W{1'b0}};
      count_r    <= {(ADDR_W+1){1'b0}};
      view_r     <= {ADDR_W{1'b0}};
      overflow_r <= 1'b0;
      valid_r    <= 1'b0;
      stepQ_r    <= 1'b0;
    end else begin
      wrPtr_r    <= wrPtrNext_s;
      count_r    <= countNext_s;
      view_r     <= viewNext_s;
      overflow_r <= overflowNext_s;
      valid_r    <= (countNext_s != {(ADDR_W+1){1'b0}});
      stepQ_r    <= Step;
    end
  end

  // Trace storage; contents survive Clear, only the pointers are flushed.
  always_ff @(posedge Clock) begin
    if (capture_s && !Reset) begin
      mem_r[wrPtr_r] <= {RegDest_In, WriteData_In, PC_In};
    end
  end

  // Registered readout of the viewed entry, zero when the buffer is empty.
  always_ff @(posedge Clock) begin
    if (Reset || Clear || (count_r == {(ADDR_W+1){1'b0}})) begin
      traceDest_r <= 5'd0;
      traceData_r <= 32'd0;
      tracePc_r   <= 32'd0;
    end else begin
      traceDest_r <= mem_r[viewAddr_s][68:64];
      traceData_r <= mem_r[viewAddr_s][63:32];
      tracePc_r   <= mem_r[viewAddr_s][31:0];
    end
  end

  assign Trace_RegDest = traceDest_r;
  assign Trace_Data    = traceData_r;
  assign Trace_PC      = tracePc_r;
  assign Trace_Index   = view_r;
  assign Count         = count_r;
  assign Valid         = valid_r;
  assign Overflow      = overflow_r;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_wb_trace_buffer;

  logic        Clock = 1'b0;
  logic        Reset, RegWrite_In, Freeze, Step, Clear;
  logic [4:0]  RegDest_In;
  logic [31:0] WriteData_In, PC_In;
  logic [4:0]  Trace_RegDest;
  logic [31:0] Trace_Data, Trace_PC;
  logic [3:0]  Trace_Index;
  logic [4:0]  Count;
  logic        Valid, Overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        full;
    logic [4:0]  cnt;
    logic        vld;
    logic        ovf;
    logic [3:0]  idx;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t expQ[$];

  wb_trace_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .RegWrite_In(RegWrite_In),
    .RegDest_In(RegDest_In), .WriteData_In(WriteData_In), .PC_In(PC_In),
    .Freeze(Freeze), .Step(Step), .Clear(Clear),
    .Trace_RegDest(Trace_RegDest), .Trace_Data(Trace_Data),
    .Trace_PC(Trace_PC), .Trace_Index(Trace_Index), .Count(Count),
    .Valid(Valid), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, compared at the falling edge.
  always @(negedge Clock) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      chk("Count", {27'd0, Count}, {27'd0, e.cnt});
      chk("Valid", {31'd0, Valid}, {31'd0, e.vld});
      chk("Overflow", {31'd0, Overflow}, {31'd0, e.ovf});
      chk("Trace_Index", {28'd0, Trace_Index}, {28'd0, e.idx});
      if (e.full) begin
        chk("Trace_RegDest", {27'd0, Trace_RegDest}, {27'd0, e.dest});
        chk("Trace_Data", Trace_Data, e.data);
        chk("Trace_PC", Trace_PC, e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expS(input logic [4:0] c, input logic o, input logic [3:0] ix);
    exp_t e;
    e.full = 1'b0; e.cnt = c; e.vld = (c != 5'd0); e.ovf = o; e.idx = ix;
    e.dest = 5'd0; e.data = 32'd0; e.pc = 32'd0;
    expQ.push_back(e);
  endtask

  task automatic expF(input logic [4:0] c, input logic o, input logic [3:0] ix,
                      input logic [4:0] d, input logic [31:0] da, input logic [31:0] p);
    exp_t e;
    e.full = 1'b1; e.cnt = c; e.vld = (c != 5'd0); e.ovf = o; e.idx = ix;
    e.dest = d; e.data = da; e.pc = p;
    expQ.push_back(e);
  endtask

  task automatic drvWrite(input logic we, input logic [4:0] d, input logic [31:0] da, input logic [31:0] p);
    RegWrite_In = we; RegDest_In = d; WriteData_In = da; PC_In = p;
  endtask

  // Index after each step pulse with 3 entries, and the entry then shown.
  logic [3:0]  stepIdx  [4] = '{4'd1, 4'd2, 4'd0, 4'd1};
  logic [4:0]  stepDest [4] = '{5'd2, 5'd3, 5'd1, 5'd2};
  logic [31:0] stepData [4] = '{32'h22, 32'h33, 32'h11, 32'h22};
  logic [31:0] stepPc   [4] = '{32'h0C, 32'h10, 32'h04, 32'h0C};

  initial begin
    Reset = 1'b1; Freeze = 1'b0; Step = 1'b0; Clear = 1'b0;
    drvWrite(1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    tick();
    expF(5'd0, 1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
    Reset = 1'b0;

    // Basic capture; r0 write is discarded.
    drvWrite(1'b1, 5'd1, 32'h11, 32'h04);
    tick(); expS(5'd1, 1'b0, 4'd0);
    drvWrite(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h08);
    tick(); expF(5'd1, 1'b0, 4'd0, 5'd1, 32'h11, 32'h04);
    drvWrite(1'b1, 5'd2, 32'h22, 32'h0C);
    tick(); expF(5'd2, 1'b0, 4'd0, 5'd1, 32'h11, 32'h04);
    drvWrite(1'b1, 5'd3, 32'h33, 32'h10);
    tick(); expF(5'd3, 1'b0, 4'd0, 5'd1, 32'h11, 32'h04);
    drvWrite(1'b0, 5'd0, 32'd0, 32'd0);

    // Step pulses: index moves at the edge, data one cycle later.
    for (int i = 0; i < 4; i++) begin
      Step = 1'b1;
      tick(); expS(5'd3, 1'b0, stepIdx[i]);
      Step = 1'b0;
      tick(); expF(5'd3, 1'b0, stepIdx[i], stepDest[i], stepData[i], stepPc[i]);
    end
    // Held step advances once.
    Step = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    Step = 1'b0;
    tick(); expF(5'd3, 1'b0, 4'd2, 5'd3, 32'h33, 32'h10);

    // Freeze blocks capture but not stepping.
    Freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drvWrite(1'b1, 5'd5 + 5'(i), 32'h55 + 32'(i), 32'h40);
      tick();
    end
    expS(5'd3, 1'b0, 4'd2);
    drvWrite(1'b0, 5'd0, 32'd0, 32'd0);
    Step = 1'b1;
    tick(); expS(5'd3, 1'b0, 4'd0);
    Step = 1'b0;
    tick(); expF(5'd3, 1'b0, 4'd0, 5'd1, 32'h11, 32'h04);
    Freeze = 1'b0;
    drvWrite(1'b1, 5'd4, 32'h44, 32'h14);
    tick(); expS(5'd4, 1'b0, 4'd0);
    drvWrite(1'b0, 5'd0, 32'd0, 32'd0);
    tick(); expF(5'd4, 1'b0, 4'd0, 5'd1, 32'h11, 32'h04);

    // Clear wins over a simultaneous capture and step edge.
    drvWrite(1'b1, 5'd7, 32'h77, 32'h18);
    Step = 1'b1; Clear = 1'b1;
    tick(); expF(5'd0, 1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
    drvWrite(1'b0, 5'd0, 32'd0, 32'd0);
    Step = 1'b0; Clear = 1'b0;
    tick(); expF(5'd0, 1'b0, 4'd0, 5'd0, 32'd0, 32'd0);

    // 18 captures into 16 entries: oldest two lost.
    for (int i = 1; i <= 18; i++) begin
      drvWrite(1'b1, 5'(i), 32'(i), 32'(i * 4));
      tick();
      if (i == 16) expS(5'd16, 1'b0, 4'd0);
      if (i == 17) expS(5'd16, 1'b1, 4'd0);
    end
    drvWrite(1'b0, 5'd0, 32'd0, 32'd0);
    tick(); expF(5'd16, 1'b1, 4'd0, 5'd3, 32'd3, 32'd12);
    for (int i = 1; i <= 15; i++) begin
      Step = 1'b1; tick();
      Step = 1'b0; tick();
    end
    expF(5'd16, 1'b1, 4'd15, 5'd18, 32'd18, 32'd72);
    // Wrap from the last index back to 0.
    Step = 1'b1; tick(); expS(5'd16, 1'b1, 4'd0);
    Step = 1'b0; tick(); expF(5'd16, 1'b1, 4'd0, 5'd3, 32'd3, 32'd12);
    for (int i = 1; i <= 5; i++) begin
      Step = 1'b1; tick();
      Step = 1'b0; tick();
    end
    expF(5'd16, 1'b1, 4'd5, 5'd8, 32'd8, 32'd32);

    // Overwrite while viewing index 5: view shifts to the old index 6 entry.
    drvWrite(1'b1, 5'd19, 32'd19, 32'd76);
    tick(); expS(5'd16, 1'b1, 4'd5);
    drvWrite(1'b0, 5'd0, 32'd0, 32'd0);
    tick(); expF(5'd16, 1'b1, 4'd5, 5'd9, 32'd9, 32'd36);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge Clock);
    if (expQ.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
